// File: rtl/x_vector_mem_responder_pkg.sv
// Shared widths, error-flag bit positions and helpers for the x-vector memory responder.
package x_vector_mem_responder_pkg;

    localparam int ADDR_W            = 48;
    localparam int DATA_W            = 64;
    localparam int DEFAULT_TAG_WIDTH = 5;
    localparam int ERR_W             = 2;
    localparam int ERR_OVF_BIT       = 0;
    localparam int ERR_SPUR_BIT      = 1;

    typedef enum logic [1:0] {
        OCC_HOLD = 2'b00,
        OCC_DEC  = 2'b01,
        OCC_INC  = 2'b10,
        OCC_BOTH = 2'b11
    } occ_op_e;

    // Sticky accumulation of the two error sources into the flag vector.
    function automatic logic [ERR_W-1:0] err_merge(
        input logic [ERR_W-1:0] cur,
        input logic             ovf,
        input logic             spur
    );
        logic [ERR_W-1:0] res;
        res               = cur;
        res[ERR_OVF_BIT]  = cur[ERR_OVF_BIT] | ovf;
        res[ERR_SPUR_BIT] = cur[ERR_SPUR_BIT] | spur;
        return res;
    endfunction

endpackage

// File: rtl/x_vector_mem_responder_fifo.sv
// std_fifo: power-of-two synchronous FIFO with show-ahead head output.
// A push on a full FIFO is accepted when a pop happens in the same cycle.
module std_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Accept/advance decisions for both pointers.
    always_comb begin
        pop_ok_s  = pop_i && !empty_o;
        push_ok_s = push_i && (!full_o || pop_ok_s);
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/x_vector_mem_responder.sv
// Forwards x-vector cache reads to the memory controller with ROB-based in-order return.
// Build option: X_RSP_BYPASS_EN lets a head-of-line response skip the ROB (latency 1).
module x_vector_mem_responder
    import x_vector_mem_responder_pkg::*;
#(
    parameter int TAG_WIDTH      = DEFAULT_TAG_WIDTH,
    parameter int REQ_FIFO_DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_mem,
    input  logic [ADDR_W-1:0]    req_mem_addr,
    output logic                 rsp_mem_push,
    output logic [DATA_W-1:0]    rsp_mem_q,
    output logic                 mc_rd_req,
    output logic [ADDR_W-1:0]    mc_rd_addr,
    output logic [TAG_WIDTH-1:0] mc_rd_tag,
    input  logic                 mc_rd_stall,
    input  logic                 mc_rsp_push,
    input  logic [TAG_WIDTH-1:0] mc_rsp_tag,
    input  logic [DATA_W-1:0]    mc_rsp_data,
    output logic [ERR_W-1:0]     err
);
    localparam int                 ENTRIES = 1 << TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] OUT_MAX = (TAG_WIDTH+1)'(ENTRIES);

    logic [ADDR_W-1:0]    fifo_head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 issue_s;
    logic                 ovf_s;
    logic [TAG_WIDTH-1:0] rsp_off_s;
    logic                 rsp_inflight_s;
    logic                 rsp_spur_s;
    logic                 rsp_ok_s;
    logic                 bypass_s;
    logic                 rob_we_s;
    logic                 retire_s;
    occ_op_e              occ_op_s;

    logic                 mc_rd_req_q,    mc_rd_req_d;
    logic [ADDR_W-1:0]    mc_rd_addr_q,   mc_rd_addr_d;
    logic [TAG_WIDTH-1:0] mc_rd_tag_q,    mc_rd_tag_d;
    logic                 rsp_mem_push_q, rsp_mem_push_d;
    logic [DATA_W-1:0]    rsp_mem_q_q,    rsp_mem_q_d;
    logic [TAG_WIDTH-1:0] issue_ptr_q,    issue_ptr_d;
    logic [TAG_WIDTH-1:0] retire_ptr_q,   retire_ptr_d;
    logic [TAG_WIDTH:0]   outstanding_q,  outstanding_d;
    logic [ENTRIES-1:0]   valid_q,        valid_d;
    logic [ERR_W-1:0]     err_q,          err_d;
    logic [DATA_W-1:0]    rob_q [ENTRIES];

    std_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (req_mem),
        .pop_i   (issue_s),
        .wdata_i (req_mem_addr),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Issue, response classification and retire decisions.
    always_comb begin
        issue_s = !fifo_empty_s && !mc_rd_stall && (outstanding_q < OUT_MAX);
        ovf_s   = req_mem && fifo_full_s && !issue_s;
        // A tag is in flight when it lies within outstanding slots ahead of retire_ptr.
        rsp_off_s      = mc_rsp_tag - retire_ptr_q;
        rsp_inflight_s = ({1'b0, rsp_off_s} < outstanding_q);
        rsp_spur_s     = mc_rsp_push && (valid_q[mc_rsp_tag] || !rsp_inflight_s);
        rsp_ok_s       = mc_rsp_push && !rsp_spur_s;
`ifdef X_RSP_BYPASS_EN
        bypass_s = rsp_ok_s && (mc_rsp_tag == retire_ptr_q) && !valid_q[retire_ptr_q];
`else
        bypass_s = 1'b0;
`endif
        rob_we_s = rsp_ok_s && !bypass_s;
        retire_s = valid_q[retire_ptr_q] || bypass_s;
        occ_op_s = occ_op_e'({issue_s, retire_s});
    end

    // Next-state for pointers, counters, valid bits, flags and registered outputs.
    always_comb begin
        mc_rd_req_d    = issue_s;
        mc_rd_addr_d   = issue_s ? fifo_head_s : mc_rd_addr_q;
        mc_rd_tag_d    = issue_s ? issue_ptr_q : mc_rd_tag_q;
        issue_ptr_d    = issue_s ? (issue_ptr_q + TAG_WIDTH'(1)) : issue_ptr_q;
        rsp_mem_push_d = retire_s;
        retire_ptr_d   = retire_s ? (retire_ptr_q + TAG_WIDTH'(1)) : retire_ptr_q;
        if (retire_s) begin
            rsp_mem_q_d = bypass_s ? mc_rsp_data : rob_q[retire_ptr_q];
        end else begin
            rsp_mem_q_d = rsp_mem_q_q;
        end
        case (occ_op_s)
            OCC_INC:  outstanding_d = outstanding_q + (TAG_WIDTH+1)'(1);
            OCC_DEC:  outstanding_d = outstanding_q - (TAG_WIDTH+1)'(1);
            OCC_HOLD: outstanding_d = outstanding_q;
            OCC_BOTH: outstanding_d = outstanding_q;
            default:  outstanding_d = outstanding_q;
        endcase
        valid_d = valid_q;
        for (int i = 0; i < ENTRIES; i++) begin
            if (rob_we_s && (mc_rsp_tag == TAG_WIDTH'(i))) begin
                valid_d[i] = 1'b1;
            end else if (retire_s && (retire_ptr_q == TAG_WIDTH'(i))) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
        err_d = err_merge(err_q, ovf_s, rsp_spur_s);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_rd_req_q    <= 1'b0;
            mc_rd_addr_q   <= '0;
            mc_rd_tag_q    <= '0;
            rsp_mem_push_q <= 1'b0;
            rsp_mem_q_q    <= '0;
            issue_ptr_q    <= '0;
            retire_ptr_q   <= '0;
            outstanding_q  <= '0;
            valid_q        <= '0;
            err_q          <= '0;
        end else begin
            mc_rd_req_q    <= mc_rd_req_d;
            mc_rd_addr_q   <= mc_rd_addr_d;
            mc_rd_tag_q    <= mc_rd_tag_d;
            rsp_mem_push_q <= rsp_mem_push_d;
            rsp_mem_q_q    <= rsp_mem_q_d;
            issue_ptr_q    <= issue_ptr_d;
            retire_ptr_q   <= retire_ptr_d;
            outstanding_q  <= outstanding_d;
            valid_q        <= valid_d;
            err_q          <= err_d;
        end
    end

    // Reorder-buffer data; qualified by valid_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rob_we_s) begin
            rob_q[mc_rsp_tag] <= mc_rsp_data;
        end
    end

    assign mc_rd_req    = mc_rd_req_q;
    assign mc_rd_addr   = mc_rd_addr_q;
    assign mc_rd_tag    = mc_rd_tag_q;
    assign rsp_mem_push = rsp_mem_push_q;
    assign rsp_mem_q    = rsp_mem_q_q;
    assign err          = err_q;

endmodule

// File: tb/tb_x_vector_mem_responder.sv
// Self-checking bench: queue-based reference model checked every cycle, plus directed scenarios.
module tb_x_vector_mem_responder;

    localparam int TW    = 5;
    localparam int N     = 32;
    localparam int DEPTH = 64;
`ifdef X_RSP_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_mem = 1'b0;
    logic [47:0]   req_mem_addr = '0;
    logic          rsp_mem_push;
    logic [63:0]   rsp_mem_q;
    logic          mc_rd_req;
    logic [47:0]   mc_rd_addr;
    logic [TW-1:0] mc_rd_tag;
    logic          mc_rd_stall = 1'b0;
    logic          mc_rsp_push = 1'b0;
    logic [TW-1:0] mc_rsp_tag = '0;
    logic [63:0]   mc_rsp_data = '0;
    logic [1:0]    err;

    x_vector_mem_responder #(.TAG_WIDTH(TW), .REQ_FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_mem      (req_mem),
        .req_mem_addr (req_mem_addr),
        .rsp_mem_push (rsp_mem_push),
        .rsp_mem_q    (rsp_mem_q),
        .mc_rd_req    (mc_rd_req),
        .mc_rd_addr   (mc_rd_addr),
        .mc_rd_tag    (mc_rd_tag),
        .mc_rd_stall  (mc_rd_stall),
        .mc_rsp_push  (mc_rsp_push),
        .mc_rsp_tag   (mc_rsp_tag),
        .mc_rsp_data  (mc_rsp_data),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [TW-1:0] tag;
        logic          got;
        logic [63:0]   data;
    } ent_t;

    logic [47:0]   fifo_m[$];
    ent_t          rob_m[$];
    int            issue_ptr_m = 0;
    logic [1:0]    err_m = 2'b00;
    logic          exp_req = 1'b0;
    logic [47:0]   exp_addr = '0;
    logic [TW-1:0] exp_tag = '0;
    logic          exp_push = 1'b0;
    logic [63:0]   exp_q = '0;

    initial begin
        ent_t e;
        int   m_idx;
        bit   m_ok, m_byp, m_ret, m_issue;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                fifo_m.delete();
                rob_m.delete();
                issue_ptr_m = 0;
                err_m       = 2'b00;
                exp_req     = 1'b0;
                exp_push    = 1'b0;
            end else begin
                m_issue = (fifo_m.size() > 0) && !mc_rd_stall && (rob_m.size() < N);
                m_idx = -1;
                for (int i = 0; i < rob_m.size(); i++)
                    if (rob_m[i].tag == mc_rsp_tag) m_idx = i;
                m_ok = 1'b0;
                if (mc_rsp_push && m_idx >= 0) m_ok = !rob_m[m_idx].got;
                if (mc_rsp_push && !m_ok) err_m[1] = 1'b1;
                m_byp = BYP && m_ok && (m_idx == 0);
                m_ret = m_byp;
                if (rob_m.size() > 0) if (rob_m[0].got) m_ret = 1'b1;
                exp_push = m_ret;
                if (m_ret) exp_q = m_byp ? mc_rsp_data : rob_m[0].data;
                if (m_ok && !m_byp) begin
                    e = rob_m[m_idx];
                    e.got  = 1'b1;
                    e.data = mc_rsp_data;
                    rob_m[m_idx] = e;
                end
                if (m_ret) void'(rob_m.pop_front());
                exp_req = m_issue;
                if (m_issue) begin
                    exp_addr = fifo_m.pop_front();
                    exp_tag  = TW'(issue_ptr_m);
                    e.tag  = TW'(issue_ptr_m);
                    e.got  = 1'b0;
                    e.data = '0;
                    rob_m.push_back(e);
                    issue_ptr_m = (issue_ptr_m + 1) % N;
                end
                if (req_mem) begin
                    if (fifo_m.size() < DEPTH) fifo_m.push_back(req_mem_addr);
                    else err_m[0] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_rd_req",   64'(mc_rd_req),    64'd0);
                chk("rst_rd_addr",  64'(mc_rd_addr),   64'd0);
                chk("rst_rd_tag",   64'(mc_rd_tag),    64'd0);
                chk("rst_rsp_push", 64'(rsp_mem_push), 64'd0);
                chk("rst_rsp_q",    rsp_mem_q,         64'd0);
                chk("rst_err",      64'(err),          64'd0);
            end else begin
                chk("rd_req", 64'(mc_rd_req), 64'(exp_req));
                if (exp_req) begin
                    chk("rd_addr", 64'(mc_rd_addr), 64'(exp_addr));
                    chk("rd_tag",  64'(mc_rd_tag),  64'(exp_tag));
                end
                chk("rsp_push", 64'(rsp_mem_push), 64'(exp_push));
                if (exp_push) chk("rsp_q", rsp_mem_q, exp_q);
                chk("err", 64'(err), 64'(err_m));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int          cyc = 0;
    int          n, got_n, first_k, last_k;
    logic [TW-1:0] tag_seen;
    logic [47:0] addr_seen, first_addr, last_addr;
    logic [63:0] r64;
    logic [63:0] d [4];
    int          pend[$];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        req_mem     = 1'b0;
        mc_rsp_push = 1'b0;
        mc_rd_stall = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // single request, latency pinning
        do_reset();
        req_mem = 1'b1; req_mem_addr = 48'h1000;
        step();
        req_mem = 1'b0;
        chk("t1_req_c1", 64'(mc_rd_req), 64'd0);
        step();
        chk("t1_req_c2",  64'(mc_rd_req),  64'd1);
        chk("t1_addr_c2", 64'(mc_rd_addr), 64'h1000);
        chk("t1_tag_c2",  64'(mc_rd_tag),  64'd0);
        repeat (4) step();
        mc_rsp_push = 1'b1; mc_rsp_tag = '0; mc_rsp_data = 64'hA5;
        for (int k = 1; k <= 3; k++) begin
            step();
            mc_rsp_push = 1'b0;
            chk("t1_push_lat", 64'(rsp_mem_push), 64'(k == LAT));
            if (k == LAT) chk("t1_data", rsp_mem_q, 64'hA5);
        end

        // four requests, reverse-order responses
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_mem = 1'b1; req_mem_addr = 48'h2000 + 48'(i * 8);
            step();
        end
        req_mem = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        for (int t = 3; t >= 0; t--) begin
            mc_rsp_push = 1'b1; mc_rsp_tag = TW'(t); mc_rsp_data = d[t];
            step();
        end
        mc_rsp_push = 1'b0;
        got_n = 0; first_k = 0; last_k = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) step();
            if (rsp_mem_push) begin
                if (got_n == 0) first_k = k;
                if (got_n < 4) chk("t2_order", rsp_mem_q, d[got_n]);
                got_n++;
                last_k = k;
            end
        end
        chk("t2_count",  64'(got_n),          64'd4);
        chk("t2_first",  64'(first_k),        64'(LAT));
        chk("t2_consec", 64'(last_k - first_k), 64'd3);

        // 40 back-to-back requests, ROB-limited issue and tag wrap
        do_reset();
        n = 0;
        for (int i = 0; i < 70; i++) begin
            req_mem = (i < 40); req_mem_addr = 48'(i);
            step();
            if (mc_rd_req) n++;
        end
        req_mem = 1'b0;
        chk("t3_issues", 64'(n), 64'd32);
        chk("t3_held",   64'(mc_rd_req), 64'd0);
        mc_rsp_push = 1'b1; mc_rsp_tag = '0; mc_rsp_data = 64'h1234;
        n = 0; tag_seen = '1; addr_seen = '1;
        for (int i = 0; i < 6; i++) begin
            step();
            mc_rsp_push = 1'b0;
            if (mc_rd_req) begin n++; tag_seen = mc_rd_tag; addr_seen = mc_rd_addr; end
        end
        chk("t3_extra",    64'(n),         64'd1);
        chk("t3_wrap_tag", 64'(tag_seen),  64'd0);
        chk("t3_wrap_adr", 64'(addr_seen), 64'd32);

        // overflow under stall, then drain of 64
        do_reset();
        mc_rd_stall = 1'b1;
        for (int i = 0; i < 65; i++) begin
            req_mem = 1'b1; req_mem_addr = 48'h100 + 48'(i);
            step();
        end
        req_mem = 1'b0;
        step();
        chk("t4_err_ovf", 64'(err), 64'd1);
        mc_rd_stall = 1'b0;
        n = 0; first_addr = '0; last_addr = '0;
        for (int i = 0; i < 400 && n < 64; i++) begin
            step();
            mc_rsp_push = 1'b0;
            if (mc_rd_req) begin
                if (n == 0) first_addr = mc_rd_addr;
                last_addr = mc_rd_addr;
                n++;
                mc_rsp_push = 1'b1; mc_rsp_tag = mc_rd_tag; mc_rsp_data = {$urandom, $urandom};
            end
        end
        chk("t4_issues", 64'(n),          64'd64);
        chk("t4_first",  64'(first_addr), 64'h100);
        chk("t4_last",   64'(last_addr),  64'h13F);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            mc_rsp_push = 1'b0;
            if (mc_rd_req) n++;
        end
        chk("t4_no_more", 64'(n),   64'd0);
        chk("t4_err",     64'(err), 64'd1);

        // spurious response, then reset mid-stream
        do_reset();
        mc_rsp_push = 1'b1; mc_rsp_tag = TW'(7); mc_rsp_data = 64'hDEAD;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            mc_rsp_push = 1'b0;
            if (rsp_mem_push) n++;
        end
        chk("t5_err_spur", 64'(err), 64'd2);
        chk("t5_no_push",  64'(n),   64'd0);
        for (int i = 0; i < 3; i++) begin
            req_mem = 1'b1; req_mem_addr = 48'hABC0 + 48'(i);
            step();
        end
        req_mem = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_req",  64'(mc_rd_req),    64'd0);
        chk("t5_rst_addr", 64'(mc_rd_addr),   64'd0);
        chk("t5_rst_tag",  64'(mc_rd_tag),    64'd0);
        chk("t5_rst_push", 64'(rsp_mem_push), 64'd0);
        chk("t5_rst_err",  64'(err),          64'd0);
        step();
        rst = 1'b0;
        mc_rsp_push = 1'b1; mc_rsp_tag = TW'(0); mc_rsp_data = 64'h55;
        step();
        mc_rsp_push = 1'b0;
        chk("t5_post_rst_spur", 64'(err), 64'd2);

        // randomized traffic with a reset partway through
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            req_mem = ($urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 30 : 80));
            r64 = {$urandom, $urandom};
            req_mem_addr = r64[47:0];
            mc_rd_stall = ($urandom_range(0, 99) < 20);
            mc_rsp_push = 1'b0;
            pend.delete();
            for (int j = 0; j < rob_m.size(); j++)
                if (!rob_m[j].got) pend.push_back(int'(rob_m[j].tag));
            if (pend.size() > 0 && $urandom_range(0, 99) < 45) begin
                mc_rsp_push = 1'b1;
                mc_rsp_tag  = TW'(pend[$urandom_range(0, pend.size() - 1)]);
            end else if ($urandom_range(0, 99) < 3) begin
                mc_rsp_push = 1'b1;
                mc_rsp_tag  = TW'($urandom_range(0, N - 1));
            end
            mc_rsp_data = {$urandom, $urandom};
            step();
        end
        idle_inputs();
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/x_vector_mem_responder.md
X_VECTOR_MEM_RESPONDER -- requirements
Module: x_vector_mem_responder

Interface
REQ-001 Parameter TAG_WIDTH, default 5, log2 of reorder-buffer (ROB) entries and maximum outstanding memory reads.
REQ-002 Parameter REQ_FIFO_DEPTH, default 64, request FIFO entries (power of two).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_mem  input  1  read request strobe from the x-vector cache; one request per asserted cycle.
REQ-006 req_mem_addr  input  48  byte address of the requested 64-bit x value.
REQ-007 rsp_mem_push  output  1  one-cycle strobe carrying read data back to the cache, in request order.
REQ-008 rsp_mem_q  output  64  read data; valid only when rsp_mem_push=1.
REQ-009 mc_rd_req  output  1  read issue strobe to the memory controller.
REQ-010 mc_rd_addr  output  48  issued address, req_mem_addr forwarded unchanged.
REQ-011 mc_rd_tag  output  TAG_WIDTH  ROB slot tag for the issued read.
REQ-012 mc_rd_stall  input  1  controller backpressure; no issue in a cycle where it is high.
REQ-013 mc_rsp_push  input  1  controller read-data strobe; responses arrive in any order.
REQ-014 mc_rsp_tag  input  TAG_WIDTH  tag of the returning response.
REQ-015 mc_rsp_data  input  64  returning data.
REQ-016 err  output  2  sticky flags: bit0 request overflow, bit1 spurious response.

Function
REQ-017 Every cycle with req_mem=1 shall push req_mem_addr into the request FIFO; no backpressure to the cache exists.
REQ-018 req_mem while the FIFO is full shall drop the request and set err[0]; push and pop in the same cycle on a full FIFO shall be accepted.
REQ-019 Issue shall occur when FIFO non-empty, mc_rd_stall=0 and outstanding < 2^TAG_WIDTH: registered mc_rd_req=1, mc_rd_addr=FIFO head, mc_rd_tag=issue_ptr; FIFO pops; issue_ptr increments modulo 2^TAG_WIDTH.
REQ-020 Minimum latency req_mem to mc_rd_req shall be 2 cycles (FIFO write, then registered issue).
REQ-021 mc_rsp_push shall write mc_rsp_data into ROB[mc_rsp_tag] and set valid[mc_rsp_tag].
REQ-022 A response whose tag is already valid or not outstanding shall be discarded and set err[1].
REQ-023 Retire: when valid[retire_ptr]=1, next cycle rsp_mem_push=1, rsp_mem_q=ROB[retire_ptr]; clear valid; retire_ptr increments modulo 2^TAG_WIDTH; at most one retire per cycle.
REQ-024 Without bypass, rsp_mem_push for the head tag shall follow its mc_rsp_push by exactly 2 cycles.
REQ-025 outstanding counter (TAG_WIDTH+1 bits): +1 on issue, -1 on retire, unchanged when both occur in the same cycle.
REQ-026 Response write and retire of different slots in the same cycle shall both take effect.
REQ-027 Pointer wrap from 2^TAG_WIDTH-1 to 0 shall not disturb ordering.

Reset
REQ-028 rst shall clear FIFO, issue_ptr, retire_ptr, outstanding, all valid bits and err; drive mc_rd_req=0, rsp_mem_push=0, mc_rd_addr=0, mc_rd_tag=0, rsp_mem_q=0.
REQ-029 Reset mid-operation shall abandon outstanding reads; responses arriving after reset release shall be treated as spurious (err[1]).

Configuration
REQ-030 Macro X_RSP_BYPASS_EN defined: a response whose tag equals retire_ptr with valid[retire_ptr]=0 shall drive rsp_mem_push/rsp_mem_q the next cycle, skip the ROB write, and advance retire_ptr (latency 1).
REQ-031 Macro undefined: all responses go through the ROB; latency per REQ-024.

Structure
REQ-032 Shared package holds address width 48, data width 64, default TAG_WIDTH and the err bit indices.
REQ-033 Request FIFO shall be an instance of the existing std_fifo sub-module; ROB and control stay in this module.

Verification
REQ-034 Single request addr 0x1000, controller returns tag 0 after 5 cycles, data 0xA5 -> mc_rd_req at cycle 2, rsp_mem_push with 0xA5 two cycles after mc_rsp_push (one with X_RSP_BYPASS_EN).
REQ-035 Four requests, responses tagged 3,2,1,0 -> rsp_mem_q emitted in order of tags 0,1,2,3, on consecutive cycles after tag 0 arrives.
REQ-036 40 back-to-back requests, no responses -> exactly 32 issues, then mc_rd_req held 0; returning tag 0 allows one more issue.
REQ-037 65 requests with mc_rd_stall=1 -> err[0]=1, 64 requests later issued.
REQ-038 Response tag 7 with nothing outstanding -> err[1]=1, no rsp_mem_push; rst mid-stream -> all outputs 0, err cleared.
